lpddr5_req_queue: RTL and testbench

Two-class request buffer sitting directly upstream of lpddr5_controller, driving its cmd_valid/cmd_rw/cmd_priority/cmd_addr/cmd_wdata inputs and consuming its cmd_ready.
It accepts host requests and sorts them into a high- and a low-priority FIFO.
It arbitrates between the two with a starvation bound and keeps same-address requests in order.
Output is a single registered stage that holds stable until the controller accepts it.

---
 rtl/lpddr5_req_queue_pkg.sv | 16 +
 rtl/lpddr5_req_fifo.sv | 57 +++++
 rtl/lpddr5_req_queue.sv | 134 +++++++++++++
 tb/tb_lpddr5_req_queue.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lpddr5_req_queue_pkg.sv
// Shared geometry and request entry type for the LPDDR5 request queue and controller.
package lpddr5_req_queue_pkg;

  localparam int ADDR_WIDTH       = 32;
  localparam int PRIORITY_WIDTH   = 2;
  localparam int DEF_DATA_BITS    = 32;
  localparam int DEF_BURST_LENGTH = 16;

  typedef struct packed {
    logic                                      rw;
    logic [PRIORITY_WIDTH-1:0]                 prio;
    logic [ADDR_WIDTH-1:0]                     addr;
    logic [DEF_DATA_BITS*DEF_BURST_LENGTH-1:0] wdata;
  } req_entry_t;

endpackage

// File: rtl/lpddr5_req_fifo.sv
// Circular request FIFO with an address-match vector over its currently valid entries.
module lpddr5_req_fifo
  import lpddr5_req_queue_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = req_entry_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  entry_t                     push_entry,
  input  logic                       pop,
  output entry_t                     head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic [ADDR_WIDTH-1:0]      match_addr,
  output logic [DEPTH-1:0]           match_vec
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] offset;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Payload storage carries no reset; validity comes solely from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    offset    = '0;
    match_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset       = PTR_W'(i) - rd_ptr;
      match_vec[i] = ({1'b0, offset} < count) && (mem[i].addr == match_addr);
    end
  end

endmodule

// File: rtl/lpddr5_req_queue.sv
// Two-class request buffer ahead of lpddr5_controller: hazard-aware class selection,
// starvation-bounded arbitration and a single registered output stage.
module lpddr5_req_queue
  import lpddr5_req_queue_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int DATA_BITS    = 32,
  parameter int BURST_LENGTH = 16,
  parameter int HI_PRIO_MIN  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_rw,
  input  logic [PRIORITY_WIDTH-1:0]         in_priority,
  input  logic [ADDR_WIDTH-1:0]             in_addr,
  input  logic [DATA_BITS*BURST_LENGTH-1:0] in_wdata,
  output logic                              cmd_valid,
  input  logic                              cmd_ready,
  output logic                              cmd_rw,
  output logic [PRIORITY_WIDTH-1:0]         cmd_priority,
  output logic [ADDR_WIDTH-1:0]             cmd_addr,
  output logic [DATA_BITS*BURST_LENGTH-1:0] cmd_wdata,
  output logic [$clog2(DEPTH+1)-1:0]        hi_count,
  output logic [$clog2(DEPTH+1)-1:0]        lo_count,
  output logic                              demote_pulse
);

  localparam int CNT_W    = $clog2(DEPTH+1);
  localparam int STARVE_W = $clog2(STARVE_LIMIT+1);

  typedef struct packed {
    logic                              rw;
    logic [PRIORITY_WIDTH-1:0]         prio;
    logic [ADDR_WIDTH-1:0]             addr;
    logic [DATA_BITS*BURST_LENGTH-1:0] wdata;
  } entry_t;

  entry_t              in_entry;
  entry_t              hi_head;
  entry_t              lo_head;
  logic [DEPTH-1:0]    hi_match;
  logic [DEPTH-1:0]    lo_match;
  logic                accept;
  logic                prio_hi;
  logic                to_lo;
  logic                reclass;
  logic                hi_empty;
  logic                lo_empty;
  logic                out_free;
  logic                pick_hi;
  logic                pop_hi;
  logic                pop_lo;
  logic [STARVE_W-1:0] starve;

  assign in_entry = '{rw: in_rw, prio: in_priority, addr: in_addr, wdata: in_wdata};
  assign in_ready = (hi_count < CNT_W'(DEPTH)) && (lo_count < CNT_W'(DEPTH));
  assign accept   = in_valid && in_ready;

  // A queued low match pins the request low, else a high match pins it high, so a
  // given address only ever lives in one FIFO and same-address order is preserved.
  assign prio_hi = int'(in_priority) >= HI_PRIO_MIN;
  assign to_lo   = (|lo_match) || (!(|hi_match) && !prio_hi);
  assign reclass = (to_lo == prio_hi);

  assign hi_empty = (hi_count == '0);
  assign lo_empty = (lo_count == '0);
  assign out_free = !cmd_valid || cmd_ready;
  assign pick_hi  = !hi_empty && (lo_empty || (starve < STARVE_W'(STARVE_LIMIT)));
  assign pop_hi   = out_free && pick_hi;
  assign pop_lo   = out_free && !pick_hi && !lo_empty;

  lpddr5_req_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_hi_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (accept && !to_lo),
    .push_entry (in_entry),
    .pop        (pop_hi),
    .head       (hi_head),
    .count      (hi_count),
    .match_addr (in_addr),
    .match_vec  (hi_match)
  );

  lpddr5_req_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_lo_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (accept && to_lo),
    .push_entry (in_entry),
    .pop        (pop_lo),
    .head       (lo_head),
    .count      (lo_count),
    .match_addr (in_addr),
    .match_vec  (lo_match)
  );

  // Output stage only advances when empty or being taken, so fields hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid    <= 1'b0;
      cmd_rw       <= 1'b0;
      cmd_priority <= '0;
      cmd_addr     <= '0;
      cmd_wdata    <= '0;
    end else if (out_free) begin
      cmd_valid <= pop_hi || pop_lo;
      if (pop_hi) begin
        cmd_rw       <= hi_head.rw;
        cmd_priority <= hi_head.prio;
        cmd_addr     <= hi_head.addr;
        cmd_wdata    <= hi_head.wdata;
      end else if (pop_lo) begin
        cmd_rw       <= lo_head.rw;
        cmd_priority <= lo_head.prio;
        cmd_addr     <= lo_head.addr;
        cmd_wdata    <= lo_head.wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve       <= '0;
      demote_pulse <= 1'b0;
    end else begin
      demote_pulse <= accept && reclass;
      if (pop_hi && !lo_empty)    starve <= starve + STARVE_W'(1);
      else if (pop_lo || lo_empty) starve <= '0;
    end
  end

endmodule

// File: tb/tb_lpddr5_req_queue.sv
// Scoreboard bench for lpddr5_req_queue: expected grants queued in arbitration order.
module tb_lpddr5_req_queue;
  import lpddr5_req_queue_pkg::*;

  localparam int WD_W  = 512;
  localparam int CNT_W = 4;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_rw;
  logic [PRIORITY_WIDTH-1:0] in_priority;
  logic [ADDR_WIDTH-1:0]     in_addr;
  logic [WD_W-1:0]           in_wdata;
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_rw;
  logic [PRIORITY_WIDTH-1:0] cmd_priority;
  logic [ADDR_WIDTH-1:0]     cmd_addr;
  logic [WD_W-1:0]           cmd_wdata;
  logic [CNT_W-1:0]          hi_count;
  logic [CNT_W-1:0]          lo_count;
  logic                      demote_pulse;

  typedef struct {
    logic                      rw;
    logic [PRIORITY_WIDTH-1:0] prio;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [WD_W-1:0]           wdata;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   total_checks = 0;
  int   bad_checks   = 0;

  lpddr5_req_queue dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rw        (in_rw),
    .in_priority  (in_priority),
    .in_addr      (in_addr),
    .in_wdata     (in_wdata),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_rw       (cmd_rw),
    .cmd_priority (cmd_priority),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .hi_count     (hi_count),
    .lo_count     (lo_count),
    .demote_pulse (demote_pulse)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [WD_W-1:0] got, input logic [WD_W-1:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WD_W-1:0] makeWdata(input logic [31:0] w0);
    logic [WD_W-1:0] w;
    for (int i = 0; i < WD_W/32; i++) w[i*32 +: 32] = $urandom;
    w[31:0] = w0;
    return w;
  endfunction

  // Drives one request across a single edge; the caller guarantees in_ready is high.
  task automatic applyStimulus(input logic rw, input logic [PRIORITY_WIDTH-1:0] prio,
                               input logic [ADDR_WIDTH-1:0] addr, input logic [31:0] w0,
                               input bit to_sb, output exp_t e);
    e.rw = rw; e.prio = prio; e.addr = addr; e.wdata = makeWdata(w0);
    in_valid = 1'b1; in_rw = rw; in_priority = prio; in_addr = addr; in_wdata = e.wdata;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (to_sb) sbq.push_back(e);
  endtask

  // Every handshake seen just before the edge must match the oldest expected grant.
  always @(negedge clk) begin
    if (rst_n && cmd_valid && cmd_ready) begin
      checkOutput("sb_nonempty", WD_W'(sbq.size() != 0), WD_W'(1));
      if (sbq.size() != 0) begin
        mon_e = sbq.pop_front();
        checkOutput("cmd_addr", WD_W'(cmd_addr), WD_W'(mon_e.addr));
        checkOutput("cmd_rw", WD_W'(cmd_rw), WD_W'(mon_e.rw));
        checkOutput("cmd_prio", WD_W'(cmd_priority), WD_W'(mon_e.prio));
        checkOutput("cmd_wdata", cmd_wdata, mon_e.wdata);
      end
    end
  end

  task automatic drainAndCheck(input int n, input string tag);
    repeat (n) begin
      @(negedge clk);
      checkOutput({tag, "_b2b"}, WD_W'(cmd_valid), WD_W'(1));
    end
    @(posedge clk); #1;
    checkOutput({tag, "_idle"}, WD_W'(cmd_valid), WD_W'(0));
    checkOutput({tag, "_sb_left"}, WD_W'(sbq.size()), WD_W'(0));
  endtask

  exp_t e, blk, ea, eb, ew, er, eha, ehb;
  exp_t hq[6];
  exp_t lq[2];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_rw = 1'b0; in_priority = '0;
    in_addr = '0; in_wdata = '0; cmd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cmd_valid", WD_W'(cmd_valid), WD_W'(0));
    checkOutput("rst_cmd_addr", WD_W'(cmd_addr), WD_W'(0));
    checkOutput("rst_cmd_wdata", cmd_wdata, WD_W'(0));
    checkOutput("rst_hi_count", WD_W'(hi_count), WD_W'(0));
    checkOutput("rst_lo_count", WD_W'(lo_count), WD_W'(0));
    checkOutput("rst_demote", WD_W'(demote_pulse), WD_W'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_in_ready", WD_W'(in_ready), WD_W'(1));

    // Single write: visible one edge after the accept edge
    cmd_ready = 1'b1;
    applyStimulus(1'b1, 2'd0, 32'h1000, 32'hdeadbeef, 1'b1, e);
    checkOutput("lat_not_yet", WD_W'(cmd_valid), WD_W'(0));
    checkOutput("lat_lo_one", WD_W'(lo_count), WD_W'(1));
    @(posedge clk); #1;
    checkOutput("lat_valid", WD_W'(cmd_valid), WD_W'(1));
    checkOutput("lat_word0", WD_W'(cmd_wdata[31:0]), WD_W'(32'hdeadbeef));
    checkOutput("lat_lo_zero", WD_W'(lo_count), WD_W'(0));
    @(posedge clk); #1;
    checkOutput("single_idle", WD_W'(cmd_valid), WD_W'(0));
    checkOutput("single_sb", WD_W'(sbq.size()), WD_W'(0));

    // Fill: one in the output register plus DEPTH queued
    cmd_ready = 1'b0;
    for (int i = 0; i < 9; i++)
      applyStimulus(i[0], PRIORITY_WIDTH'(i % 2), 32'h3000 + 32'(i) * 32'h40, 32'(i), 1'b1, e);
    checkOutput("full_lo_count", WD_W'(lo_count), WD_W'(8));
    checkOutput("full_in_ready", WD_W'(in_ready), WD_W'(0));
    in_valid = 1'b1; in_addr = 32'h5000; in_priority = 2'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("full_no_accept", WD_W'(lo_count), WD_W'(8));
    checkOutput("full_hi_zero", WD_W'(hi_count), WD_W'(0));
    cmd_ready = 1'b1;
    drainAndCheck(9, "fill");

    // Backpressure hold, then next entry loads right after release
    cmd_ready = 1'b0;
    applyStimulus(1'b1, 2'd1, 32'h4000, 32'h11111111, 1'b1, ea);
    applyStimulus(1'b0, 2'd0, 32'h4040, 32'h22222222, 1'b1, eb);
    repeat (5) begin
      @(negedge clk);
      checkOutput("hold_valid", WD_W'(cmd_valid), WD_W'(1));
      checkOutput("hold_addr", WD_W'(cmd_addr), WD_W'(ea.addr));
      checkOutput("hold_wdata", cmd_wdata, ea.wdata);
    end
    @(posedge clk); #1;
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("hold_next_addr", WD_W'(cmd_addr), WD_W'(eb.addr));
    @(posedge clk); #1;
    checkOutput("hold_idle", WD_W'(cmd_valid), WD_W'(0));
    checkOutput("hold_sb", WD_W'(sbq.size()), WD_W'(0));

    // Starvation bound: blocker parked in the output, then 6 high + 2 low
    cmd_ready = 1'b0;
    applyStimulus(1'b0, 2'd0, 32'h7000, 32'h70, 1'b1, blk);
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b0, 2'd3, 32'h8000 + 32'(i) * 32'h40, 32'h80 + 32'(i), 1'b0, hq[i]);
    for (int i = 0; i < 2; i++)
      applyStimulus(1'b1, 2'd1, 32'h9000 + 32'(i) * 32'h40, 32'h90 + 32'(i), 1'b0, lq[i]);
    checkOutput("arb_hi_count", WD_W'(hi_count), WD_W'(6));
    checkOutput("arb_lo_count", WD_W'(lo_count), WD_W'(2));
    for (int i = 0; i < 4; i++) sbq.push_back(hq[i]);
    sbq.push_back(lq[0]);
    sbq.push_back(hq[4]);
    sbq.push_back(hq[5]);
    sbq.push_back(lq[1]);
    cmd_ready = 1'b1;
    drainAndCheck(9, "arb");

    // Address hazards: high read behind low write goes low; low read behind high goes high
    cmd_ready = 1'b0;
    applyStimulus(1'b0, 2'd0, 32'h7100, 32'h71, 1'b1, blk);
    applyStimulus(1'b1, 2'd0, 32'h2000, 32'h20, 1'b0, ew);
    checkOutput("haz_no_pulse", WD_W'(demote_pulse), WD_W'(0));
    applyStimulus(1'b0, 2'd3, 32'h2000, 32'h21, 1'b0, er);
    checkOutput("haz_demote", WD_W'(demote_pulse), WD_W'(1));
    checkOutput("haz_lo_count", WD_W'(lo_count), WD_W'(2));
    checkOutput("haz_hi_count", WD_W'(hi_count), WD_W'(0));
    applyStimulus(1'b1, 2'd3, 32'hA000, 32'hA0, 1'b0, eha);
    checkOutput("haz_hi_no_pulse", WD_W'(demote_pulse), WD_W'(0));
    applyStimulus(1'b0, 2'd0, 32'hA000, 32'hA1, 1'b0, ehb);
    checkOutput("haz_promote", WD_W'(demote_pulse), WD_W'(1));
    checkOutput("haz_hi_count2", WD_W'(hi_count), WD_W'(2));
    @(posedge clk); #1;
    checkOutput("haz_pulse_once", WD_W'(demote_pulse), WD_W'(0));
    sbq.push_back(eha);
    sbq.push_back(ehb);
    sbq.push_back(ew);
    sbq.push_back(er);
    cmd_ready = 1'b1;
    drainAndCheck(5, "haz");

    // Reset mid-stream drops everything immediately
    cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 2'd0, 32'hB000 + 32'(i) * 32'h40, 32'hB0, 1'b1, e);
    checkOutput("pre_rst_lo", WD_W'(lo_count), WD_W'(2));
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", WD_W'(cmd_valid), WD_W'(0));
    checkOutput("mid_rst_lo", WD_W'(lo_count), WD_W'(0));
    checkOutput("mid_rst_hi", WD_W'(hi_count), WD_W'(0));
    sbq.delete();
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst_ready", WD_W'(in_ready), WD_W'(1));
    checkOutput("post_rst_valid", WD_W'(cmd_valid), WD_W'(0));
    cmd_ready = 1'b1;
    applyStimulus(1'b0, 2'd2, 32'hC000, 32'hC0, 1'b1, e);
    checkOutput("post_rst_hi", WD_W'(hi_count), WD_W'(1));
    repeat (3) @(posedge clk);
    #1;
    checkOutput("post_rst_sb", WD_W'(sbq.size()), WD_W'(0));
    checkOutput("post_rst_idle", WD_W'(cmd_valid), WD_W'(0));

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
